// File: rtl/k12a_run_ctl.sv
// Run controller for the k12a core: gates the core clock enable and reset, and
// arbitrates the memory bus between the core and host commands while paused.
module k12a_run_ctl #(
  parameter int RESET_CYCLES = 4,
  parameter int MEM_LATENCY  = 1
) (
  input  logic        cpu_clock,
  input  logic        reset,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [2:0]  cmd_op,
  input  logic [15:0] cmd_addr,
  input  logic [7:0]  cmd_data,
  output logic        rsp_valid,
  output logic        rsp_err,
  output logic [7:0]  rsp_data,
  input  logic        cpu_halted,
  input  logic [15:0] cpu_pc,
  input  logic        bp_enable,
  input  logic [15:0] bp_addr,
  output logic        cpu_clk_en,
  output logic        cpu_reset_n,
  output logic        host_mem_en,
  output logic        host_mem_we,
  output logic [15:0] host_mem_addr,
  output logic [7:0]  host_mem_wdata,
  input  logic [7:0]  host_mem_rdata,
  output logic        running,
  output logic [1:0]  stop_cause,
  output logic [2:0]  fsm_state
);

  // Command handshake: a command transfers in a cycle with cmd_valid && cmd_ready;
  // responses are single-cycle rsp_valid pulses with no backpressure.
  typedef enum logic [2:0] {S_RST, S_PAUSED, S_RUN, S_STEP, S_MEM} state_t;

  localparam logic [2:0] OP_RUN  = 3'd1;
  localparam logic [2:0] OP_STOP = 3'd2;
  localparam logic [2:0] OP_STEP = 3'd3;
  localparam logic [2:0] OP_RCPU = 3'd4;
  localparam logic [2:0] OP_RD   = 3'd5;
  localparam logic [2:0] OP_WR   = 3'd6;
  localparam logic [2:0] OP_RSVD = 3'd7;

  localparam logic [15:0] RST_LAST = 16'(RESET_CYCLES - 1);
  localparam logic [15:0] MEM_LAST = 16'(MEM_LATENCY - 1);

  state_t      state, state_n;
  logic [7:0]  cnt;
  logic [15:0] tmr;
  logic        bp_armed, rst_rsp;
  logic        mem_we_q;
  logic [15:0] mem_addr_q;
  logic [7:0]  mem_wdata_q;
  logic        running_q, rsp_valid_q, rsp_err_q;
  logic [1:0]  cause_q;
  logic [7:0]  rsp_data_q;

  logic        ready, clk_en, mem_en, bp_hit;
  logic        rsp_set, err_set, cause_wr;
  logic [1:0]  cause_val;
  logic [7:0]  rsp_data_n;
  logic        paused_cmd;

  assign paused_cmd = (state == S_PAUSED) && cmd_valid;

  always_comb begin
    state_n    = state;
    ready      = 1'b0;
    clk_en     = 1'b0;
    mem_en     = 1'b0;
    bp_hit     = 1'b0;
    rsp_set    = 1'b0;
    err_set    = 1'b0;
    cause_wr   = 1'b0;
    cause_val  = 2'd0;
    rsp_data_n = 8'h00;
    case (state)
      S_RST: begin
        clk_en = 1'b1;
        if (tmr == RST_LAST) begin
          state_n  = S_PAUSED;
          cause_wr = 1'b1;
          rsp_set  = rst_rsp;
        end
      end
      S_PAUSED: begin
        ready = 1'b1;
        if (cmd_valid) begin
          case (cmd_op)
            OP_RUN:        begin state_n = S_RUN; rsp_set = 1'b1; end
            OP_STEP:       state_n = S_STEP;
            OP_RCPU:       state_n = S_RST;
            OP_RD, OP_WR:  state_n = S_MEM;
            OP_RSVD:       begin rsp_set = 1'b1; err_set = 1'b1; end
            default:       rsp_set = 1'b1;
          endcase
        end
      end
      S_RUN: begin
        ready  = 1'b1;
        bp_hit = bp_enable && bp_armed && (cpu_pc == bp_addr);
        clk_en = !cpu_halted && !bp_hit;
        if (cmd_valid) begin
          rsp_set = 1'b1;
          err_set = (cmd_op != OP_STOP);
        end
        // Hardware stop causes take priority over a coincident host STOP.
        if (cpu_halted) begin
          state_n = S_PAUSED; cause_wr = 1'b1; cause_val = 2'd1;
        end else if (bp_hit) begin
          state_n = S_PAUSED; cause_wr = 1'b1; cause_val = 2'd2;
        end else if (cmd_valid && cmd_op == OP_STOP) begin
          state_n = S_PAUSED; cause_wr = 1'b1; cause_val = 2'd0;
        end
      end
      S_STEP: begin
        if (cpu_halted) begin
          state_n = S_PAUSED; cause_wr = 1'b1; cause_val = 2'd1; rsp_set = 1'b1;
        end else begin
          clk_en = 1'b1;
          if (cnt == 8'd0) begin
            state_n = S_PAUSED; cause_wr = 1'b1; cause_val = 2'd3; rsp_set = 1'b1;
          end
        end
      end
      S_MEM: begin
        mem_en = 1'b1;
        if (tmr == MEM_LAST) begin
          state_n    = S_PAUSED;
          cause_wr   = 1'b1;
          rsp_set    = 1'b1;
          rsp_data_n = mem_we_q ? 8'h00 : host_mem_rdata;
        end
      end
      default: state_n = S_RST;
    endcase
  end

  always_ff @(posedge cpu_clock) begin
    if (reset) begin
      state       <= S_RST;
      cnt         <= 8'd0;
      tmr         <= 16'd0;
      bp_armed    <= 1'b0;
      rst_rsp     <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= 16'd0;
      mem_wdata_q <= 8'd0;
      running_q   <= 1'b0;
      cause_q     <= 2'd0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_data_q  <= 8'd0;
    end else begin
      state       <= state_n;
      // tmr counts cycles spent in the current state.
      tmr         <= (state_n != state) ? 16'd0 : tmr + 16'd1;
      running_q   <= (state_n == S_RUN);
      rsp_valid_q <= rsp_set;
      rsp_err_q   <= err_set;
      rsp_data_q  <= rsp_data_n;
      if (cause_wr) cause_q <= cause_val;
      if (paused_cmd && cmd_op == OP_STEP) cnt <= cmd_data;
      else if (state == S_STEP) cnt <= cnt - 8'd1;
      if (paused_cmd && (cmd_op == OP_RD || cmd_op == OP_WR)) begin
        mem_addr_q  <= cmd_addr;
        mem_wdata_q <= cmd_data;
        mem_we_q    <= (cmd_op == OP_WR);
      end
      // Arming waits for the PC to leave bp_addr so RUN can resume from a breakpoint.
      if (paused_cmd && cmd_op == OP_RUN) bp_armed <= 1'b0;
      else if (state == S_RUN && cpu_pc != bp_addr) bp_armed <= 1'b1;
      if (paused_cmd && cmd_op == OP_RCPU) rst_rsp <= 1'b1;
      else if (state == S_RST && state_n == S_PAUSED) rst_rsp <= 1'b0;
    end
  end

  assign cmd_ready      = ready && !reset;
  assign cpu_clk_en     = clk_en && !reset;
  assign cpu_reset_n    = (state != S_RST) && !reset;
  assign host_mem_en    = mem_en && !reset;
  assign host_mem_we    = mem_en && mem_we_q && !reset;
  assign host_mem_addr  = mem_addr_q;
  assign host_mem_wdata = mem_wdata_q;
  assign rsp_valid      = rsp_valid_q;
  assign rsp_err        = rsp_err_q;
  assign rsp_data       = rsp_data_q;
  assign running        = running_q;
  assign stop_cause     = cause_q;
  assign fsm_state      = state;

endmodule

// File: tb/tb_k12a_run_ctl.sv
// Directed bench for k12a_run_ctl: a default-parameter instance plus a
// MEM_LATENCY=3 instance used for the reset-during-access scenario.
module tb_k12a_run_ctl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, reset_b, cmd_valid, cmd_valid_b;
  logic [2:0]  cmd_op;
  logic [15:0] cmd_addr, bp_addr;
  logic [7:0]  cmd_data;
  logic        cpu_halted, bp_enable, pc_clr;
  logic [15:0] pc;

  logic        cmd_ready, rsp_valid, rsp_err, cpu_clk_en, cpu_reset_n;
  logic        host_mem_en, host_mem_we, running;
  logic [7:0]  rsp_data, host_mem_wdata, host_mem_rdata;
  logic [15:0] host_mem_addr;
  logic [1:0]  stop_cause;
  logic [2:0]  fsm_state;

  logic        cmd_ready_b, rsp_valid_b, rsp_err_b, cpu_clk_en_b, cpu_reset_n_b;
  logic        host_mem_en_b, host_mem_we_b, running_b;
  logic [7:0]  rsp_data_b, host_mem_wdata_b;
  logic [15:0] host_mem_addr_b;
  logic [1:0]  stop_cause_b;
  logic [2:0]  fsm_state_b;

  logic [7:0]  mem_model [256];
  logic [8:0]  exp_q [$];
  int          n_checks = 0;
  int          n_pass = 0;

  k12a_run_ctl dut (
    .cpu_clock(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_addr(cmd_addr), .cmd_data(cmd_data),
    .rsp_valid(rsp_valid), .rsp_err(rsp_err), .rsp_data(rsp_data),
    .cpu_halted(cpu_halted), .cpu_pc(pc), .bp_enable(bp_enable), .bp_addr(bp_addr),
    .cpu_clk_en(cpu_clk_en), .cpu_reset_n(cpu_reset_n),
    .host_mem_en(host_mem_en), .host_mem_we(host_mem_we),
    .host_mem_addr(host_mem_addr), .host_mem_wdata(host_mem_wdata),
    .host_mem_rdata(host_mem_rdata), .running(running), .stop_cause(stop_cause),
    .fsm_state(fsm_state)
  );

  k12a_run_ctl #(.RESET_CYCLES(4), .MEM_LATENCY(3)) dut_b (
    .cpu_clock(clk), .reset(reset_b), .cmd_valid(cmd_valid_b), .cmd_ready(cmd_ready_b),
    .cmd_op(cmd_op), .cmd_addr(cmd_addr), .cmd_data(cmd_data),
    .rsp_valid(rsp_valid_b), .rsp_err(rsp_err_b), .rsp_data(rsp_data_b),
    .cpu_halted(1'b0), .cpu_pc(pc), .bp_enable(1'b0), .bp_addr(16'h0000),
    .cpu_clk_en(cpu_clk_en_b), .cpu_reset_n(cpu_reset_n_b),
    .host_mem_en(host_mem_en_b), .host_mem_we(host_mem_we_b),
    .host_mem_addr(host_mem_addr_b), .host_mem_wdata(host_mem_wdata_b),
    .host_mem_rdata(8'h3C), .running(running_b), .stop_cause(stop_cause_b),
    .fsm_state(fsm_state_b)
  );

  // Core PC model: advances by 2 each enabled cycle.
  always @(posedge clk) begin
    if (pc_clr) pc <= 16'h0000;
    else if (cpu_clk_en) pc <= pc + 16'd2;
  end

  always @(posedge clk) begin
    if (host_mem_en && host_mem_we) mem_model[host_mem_addr[7:0]] <= host_mem_wdata;
  end
  assign host_mem_rdata = mem_model[host_mem_addr[7:0]];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [2:0] op, input logic [15:0] addr, input logic [7:0] data);
    cmd_op = op; cmd_addr = addr; cmd_data = data; cmd_valid = 1'b1;
    #1;
    check("cmd_ready", cmd_ready, 1);
    tick();
    cmd_valid = 1'b0; cmd_op = 3'd0;
  endtask

  task automatic check_rsp(input string tag);
    logic [8:0] e;
    e = (exp_q.size() != 0) ? exp_q.pop_front() : 9'h1FF;
    check(tag, {rsp_err, rsp_data}, e);
  endtask

  // Counts cycles (and enabled bus / core cycles) until rsp_valid, bounded.
  task automatic run_until_rsp(input int max, output int cyc, output int en_n, output int clk_n);
    cyc = 0; en_n = 0; clk_n = 0;
    #1;
    while (!rsp_valid && cyc < max) begin
      en_n += int'(host_mem_en);
      clk_n += int'(cpu_clk_en);
      cyc++;
      tick();
    end
    check("rsp_seen", rsp_valid, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish");
    $fatal(1);
  end

  initial begin
    int n, cyc, en_n, clk_n;
    logic seen6, clk6, rv;
    reset = 1; reset_b = 1; cmd_valid = 0; cmd_valid_b = 0;
    cmd_op = 0; cmd_addr = 0; cmd_data = 0;
    cpu_halted = 0; bp_enable = 0; bp_addr = 0; pc_clr = 1;
    repeat (3) tick();
    check("rst_reset_n", cpu_reset_n, 0);
    check("rst_clk_en_in_reset", cpu_clk_en, 0);
    check("rst_cmd_ready", cmd_ready, 0);
    check("rst_outs", {running, rsp_valid, host_mem_en, stop_cause}, 0);

    reset = 0; reset_b = 0; pc_clr = 0;
    #1;
    check("rst_clk_en", cpu_clk_en, 1);
    n = 0;
    while (!cpu_reset_n && n < 20) begin n++; tick(); end
    check("rst_len", n, 4);
    check("paused_ready", cmd_ready, 1);
    check("paused_clk_en", cpu_clk_en, 0);
    check("paused_cause", stop_cause, 0);

    // MEM_WR then MEM_RD
    exp_q.push_back({1'b0, 8'h00});
    send(3'd6, 16'h8010, 8'hA5);
    #1;
    check("wr_bus", {host_mem_we, host_mem_addr, host_mem_wdata}, {1'b1, 16'h8010, 8'hA5});
    run_until_rsp(10, cyc, en_n, clk_n);
    check("wr_lat", cyc, 1);
    check("wr_en_cycles", en_n, 1);
    check("wr_clk_en", clk_n, 0);
    check_rsp("wr_rsp");
    exp_q.push_back({1'b0, 8'hA5});
    send(3'd5, 16'h8010, 8'h00);
    #1;
    check("rd_we", host_mem_we, 0);
    run_until_rsp(10, cyc, en_n, clk_n);
    check("rd_lat", cyc, 1);
    check("rd_en_cycles", en_n, 1);
    check("rd_clk_en", clk_n, 0);
    check_rsp("rd_rsp");

    // STEP 3 cycles
    exp_q.push_back({1'b0, 8'h00});
    send(3'd3, 16'h0000, 8'd2);
    run_until_rsp(20, cyc, en_n, clk_n);
    check("step_clk_cycles", clk_n, 3);
    check("step_lat", cyc, 3);
    check("step_cause", stop_cause, 3);
    check_rsp("step_rsp");

    // STEP interrupted by halt on the 2nd cycle
    exp_q.push_back({1'b0, 8'h00});
    send(3'd3, 16'h0000, 8'd2);
    #1;
    check("steph_first_en", cpu_clk_en, 1);
    tick();
    cpu_halted = 1;
    run_until_rsp(20, cyc, en_n, clk_n);
    check("steph_clk_cycles", clk_n, 0);
    check("steph_cause", stop_cause, 1);
    check_rsp("steph_rsp");
    cpu_halted = 0;

    // Breakpoint at 0x0006
    bp_enable = 1; bp_addr = 16'h0006; pc_clr = 1;
    tick();
    pc_clr = 0;
    exp_q.push_back({1'b0, 8'h00});
    send(3'd1, 16'h0000, 8'h00);
    #1;
    check("run_rsp_valid", rsp_valid, 1);
    check_rsp("run_rsp");
    check("run_running", running, 1);
    n = 0; seen6 = 0; clk6 = 1;
    while (running && n < 20) begin
      if (pc == 16'h0006 && !seen6) begin seen6 = 1; clk6 = cpu_clk_en; end
      n++;
      tick();
    end
    check("bp_seen_pc6", seen6, 1);
    check("bp_clk_en", clk6, 0);
    check("bp_stopped", running, 0);
    check("bp_cause", stop_cause, 2);
    check("bp_pc", pc, 16'h0006);

    // Resume from the breakpoint address
    exp_q.push_back({1'b0, 8'h00});
    send(3'd1, 16'h0000, 8'h00);
    #1;
    check_rsp("resume_rsp");
    check("resume_clk_en", cpu_clk_en, 1);
    tick(); tick();
    check("resume_pc", pc, 16'h000A);
    check("resume_running", running, 1);

    // Illegal command in RUN, then STOP coinciding with halt
    exp_q.push_back({1'b1, 8'h00});
    send(3'd5, 16'h8010, 8'h00);
    #1;
    check("run_rd_valid", rsp_valid, 1);
    check_rsp("run_rd_rsp");
    check("run_rd_running", running, 1);
    cpu_halted = 1;
    exp_q.push_back({1'b0, 8'h00});
    send(3'd2, 16'h0000, 8'h00);
    #1;
    check("stop_valid", rsp_valid, 1);
    check_rsp("stop_rsp");
    check("stop_cause_halt", stop_cause, 1);
    check("stop_running", running, 0);
    cpu_halted = 0;

    // Reserved op and NOP in PAUSED
    exp_q.push_back({1'b1, 8'h00});
    send(3'd7, 16'h0000, 8'h00);
    #1;
    check("rsvd_valid", rsp_valid, 1);
    check_rsp("rsvd_rsp");
    check("rsvd_paused", {cmd_ready, running}, 2'b10);
    exp_q.push_back({1'b0, 8'h00});
    send(3'd0, 16'h0000, 8'h00);
    #1;
    check("nop_valid", rsp_valid, 1);
    check_rsp("nop_rsp");

    // RESET_CPU
    exp_q.push_back({1'b0, 8'h00});
    send(3'd4, 16'h0000, 8'h00);
    #1;
    n = 0; rv = 0;
    while (!cpu_reset_n && n < 20) begin rv |= rsp_valid; n++; tick(); end
    check("rcpu_len", n, 4);
    check("rcpu_early_rsp", rv, 0);
    check("rcpu_valid", rsp_valid, 1);
    check_rsp("rcpu_rsp");
    check("rcpu_cause", stop_cause, 0);

    // Reset during a 3-cycle read on the second instance
    cmd_op = 3'd5; cmd_addr = 16'h0040; cmd_valid_b = 1;
    #1;
    check("b_ready", cmd_ready_b, 1);
    tick();
    cmd_valid_b = 0;
    #1;
    check("b_en_c1", host_mem_en_b, 1);
    tick();
    check("b_en_c2", host_mem_en_b, 1);
    reset_b = 1;
    tick();
    check("b_abort_en", host_mem_en_b, 0);
    check("b_abort_rsp", rsp_valid_b, 0);
    reset_b = 0;
    #1;
    n = 0; rv = 0;
    while (!cpu_reset_n_b && n < 20) begin rv |= rsp_valid_b; n++; tick(); end
    check("b_rst_len", n, 4);
    check("b_no_rsp", {rv, rsp_valid_b}, 0);
    check("b_ready_after", cmd_ready_b, 1);

    // Fresh read on the second instance: MEM_LATENCY+1 response latency
    cmd_op = 3'd5; cmd_addr = 16'h0040; cmd_valid_b = 1;
    tick();
    cmd_valid_b = 0;
    #1;
    n = 0; en_n = 0;
    while (!rsp_valid_b && n < 20) begin en_n += int'(host_mem_en_b); n++; tick(); end
    check("b_rd_lat", n, 3);
    check("b_rd_en_cycles", en_n, 3);
    check("b_rd_rsp", {rsp_valid_b, rsp_err_b, rsp_data_b}, {2'b10, 8'h3C});

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
